// File: rtl/sb_cfg_pkg.sv
// Shared types and sizing helpers for the switch box config loader.
// Used by switch_box_cfg_loader (optional parity: SB_CFG_PARITY_EN).
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } sb_state_e;

  function automatic int calc_beats(
    input int cfg_w,
    input int in_w
  );
    return (cfg_w + in_w - 1) / in_w;
  endfunction

  function automatic int calc_cnt_w(
    input int beats
  );
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/switch_box_cfg_loader.sv
// Streams config beats into a shadow and applies them atomically on commit.
// Define SB_CFG_PARITY_EN to add in_par with per-beat even parity checking.
module switch_box_cfg_loader
  import sb_cfg_pkg::*;
#(
  parameter int CFG_W = 60,
  parameter int IN_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
`ifdef SB_CFG_PARITY_EN
  input  logic             in_par,
`endif
  output logic             in_ready,
  input  logic             commit,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_valid,
  output logic             loaded,
  output logic             busy,
  output logic             err
);

  localparam int BEATS = calc_beats(CFG_W, IN_W);
  localparam int CW    = calc_cnt_w(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  sb_state_e        state_q, state_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_out_q, cfg_out_d;
  logic [CFG_W-1:0] shadow_wr;
  logic             in_ready_q, in_ready_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             beat_fire;
  logic             par_bad;

  assign beat_fire = in_valid && in_ready_q;

`ifdef SB_CFG_PARITY_EN
  assign par_bad = ^{in_data, in_par};
`else
  assign par_bad = 1'b0;
`endif

  // Final-beat bits beyond CFG_W simply have no destination.
  always_comb begin
    shadow_wr = shadow_q;
    for (int i = 0; i < CFG_W; i++) begin
      if (i / IN_W == int'(beat_cnt_q)) begin
        shadow_wr[i] = in_data[i % IN_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    shadow_d    = shadow_q;
    cfg_out_d   = cfg_out_q;
    in_ready_d  = in_ready_q;
    loaded_d    = loaded_q;
    err_d       = err_q;
    cfg_valid_d = cfg_valid_q;
    unique case (state_q)
      IDLE: begin
        if (commit) err_d = 1'b1;
        if (cfg_start) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
          shadow_d   = '0;
          in_ready_d = 1'b1;
          err_d      = commit;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          beat_cnt_d = '0;
          shadow_d   = '0;
          err_d      = commit;
        end else begin
          if (commit) err_d = 1'b1;
          if (beat_fire) begin
            if (par_bad) begin
              state_d    = IDLE;
              err_d      = 1'b1;
              shadow_d   = '0;
              beat_cnt_d = '0;
              in_ready_d = 1'b0;
            end else begin
              shadow_d = shadow_wr;
              if (beat_cnt_q == LAST) begin
                state_d    = HOLD;
                in_ready_d = 1'b0;
                loaded_d   = 1'b1;
              end else begin
                beat_cnt_d = beat_cnt_q + CW'(1);
              end
            end
          end
        end
      end
      HOLD: begin
        if (commit) begin
          cfg_out_d   = shadow_q;
          cfg_valid_d = 1'b1;
          loaded_d    = 1'b0;
          state_d     = IDLE;
        end else if (cfg_start) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
          shadow_d   = '0;
          loaded_d   = 1'b0;
          in_ready_d = 1'b1;
          err_d      = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
        loaded_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      shadow_q    <= '0;
      cfg_out_q   <= '0;
      in_ready_q  <= 1'b0;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      shadow_q    <= shadow_d;
      cfg_out_q   <= cfg_out_d;
      in_ready_q  <= in_ready_d;
      loaded_q    <= loaded_d;
      err_q       <= err_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign cfg_out   = cfg_out_q;
  assign cfg_valid = cfg_valid_q;
  assign loaded    = loaded_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// Directed bench for switch_box_cfg_loader.
// Parity scenario runs only when SB_CFG_PARITY_EN is defined.
module tb_switch_box_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_par = 1'b0;
  logic        in_ready;
  logic        commit = 1'b0;
  logic [59:0] cfg_out;
  logic        cfg_valid;
  logic        loaded;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [59:0] IMG_SEQ = 60'h807060504030201;
  localparam logic [59:0] IMG_11  = 60'h111111111111111;
  localparam logic [59:0] IMG_A   = 60'hFEDCBA987654321;

  switch_box_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef SB_CFG_PARITY_EN
    .in_par    (in_par),
`endif
    .in_ready  (in_ready),
    .commit    (commit),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .loaded    (loaded),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic bad_par);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = (^d) ^ bad_par;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load8(input logic [63:0] img8);
    logic [63:0] v;
    v = img8;
    for (int i = 0; i < 8; i++) beat(v[i*8 +: 8], 1'b0);
  endtask

  initial begin
    logic [63:0] seq8;
    logic [63:0] a8;
    seq8 = 64'h0807060504030201;
    a8   = 64'h0FEDCBA987654321;

    #12;
    check("rst_cfg_out", 64'(cfg_out), 64'd0);
    check("rst_flags", {59'd0, cfg_valid, loaded, in_ready, busy, err}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Nominal load, in_valid held high.
    check("idle_in_ready", 64'(in_ready), 64'd0);
    start();
    check("load_in_ready", 64'(in_ready), 64'd1);
    check("load_busy", 64'(busy), 64'd1);
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      in_par  = ^in_data;
      tick();
    end
    in_valid = 1'b0;
    check("nom_loaded", 64'(loaded), 64'd1);
    check("nom_hold_ready", 64'(in_ready), 64'd0);
    check("nom_cfg_out_pre", 64'(cfg_out), 64'd0);
    do_commit();
    check("nom_cfg_out", 64'(cfg_out), 64'(IMG_SEQ));
    check("nom_flags", {61'd0, cfg_valid, loaded, busy}, 64'b100);

    // Bubbles on in_valid; a 9th beat in HOLD must be ignored.
    start();
    for (int i = 0; i < 8; i++) begin
      beat(seq8[i*8 +: 8], 1'b0);
      tick();
    end
    check("bub_loaded", 64'(loaded), 64'd1);
    beat(8'hEE, 1'b0);
    check("bub_9th_ready", 64'(in_ready), 64'd0);
    check("bub_9th_busy", 64'(busy), 64'd1);
    do_commit();
    check("bub_cfg_out", 64'(cfg_out), 64'(IMG_SEQ));

    // Restart mid-load discards the partial 0xAA image.
    start();
    for (int i = 0; i < 3; i++) beat(8'hAA, 1'b0);
    start();
    check("rs_cfg_out_hold", 64'(cfg_out), 64'(IMG_SEQ));
    for (int i = 0; i < 8; i++) beat(8'h11, 1'b0);
    do_commit();
    check("rs_cfg_out", 64'(cfg_out), 64'(IMG_11));
    check("rs_err", 64'(err), 64'd0);

    // Early commit after a fresh reset.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    start();
    for (int i = 0; i < 4; i++) beat(seq8[i*8 +: 8], 1'b0);
    do_commit();
    check("ec_err", 64'(err), 64'd1);
    check("ec_cfg_out", 64'(cfg_out), 64'd0);
    check("ec_cfg_valid", 64'(cfg_valid), 64'd0);
    for (int i = 4; i < 8; i++) beat(seq8[i*8 +: 8], 1'b0);
    check("ec_loaded", 64'(loaded), 64'd1);
    do_commit();
    check("ec_cfg_out_done", 64'(cfg_out), 64'(IMG_SEQ));
    check("ec_err_sticky", 64'(err), 64'd1);
    start();
    check("ec_err_clear", 64'(err), 64'd0);

    // Image A; commit and cfg_start together in HOLD: commit wins.
    load8(a8);
    commit    = 1'b1;
    cfg_start = 1'b1;
    tick();
    commit    = 1'b0;
    cfg_start = 1'b0;
    check("cs_cfg_out", 64'(cfg_out), 64'(IMG_A));
    check("cs_busy", 64'(busy), 64'd0);
    check("cs_err", 64'(err), 64'd0);

`ifdef SB_CFG_PARITY_EN
    start();
    for (int i = 0; i < 4; i++) beat(8'h3C, 1'b0);
    beat(8'h5A, 1'b1);
    check("par_err", 64'(err), 64'd1);
    check("par_busy", 64'(busy), 64'd0);
    check("par_loaded", 64'(loaded), 64'd0);
    check("par_cfg_out", 64'(cfg_out), 64'(IMG_A));
`endif

    // Async reset while HOLDing a new image over committed image A.
    start();
    for (int i = 0; i < 8; i++) beat(8'h77, 1'b0);
    check("ar_loaded_pre", 64'(loaded), 64'd1);
    check("ar_cfg_out_pre", 64'(cfg_out), 64'(IMG_A));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cfg_out", 64'(cfg_out), 64'd0);
    check("ar_flags", {59'd0, cfg_valid, loaded, in_ready, busy, err}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1);
  end

endmodule
